pc_seq_unit: RTL

- Registered, parametrised program-counter unit. Generalises the combinational PC+1 incrementer into a stateful sequencer.
- Supports sequential advance, conditional relative branch, absolute jump, and call/return through a small hardware return stack.
- Supports stall and halt/resume.
- Sits between instruction decode (supplies op/offset/target) and instruction memory (consumes pc).

---
 rtl/pc_seq_unit_if.sv | 35 +++
 rtl/pc_seq_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit_if.sv
// Interface between instruction decode and the program-counter sequencer.
//   master : decode side. It drives en/op/take/offset/target/halt/resume and
//            observes pc/npc/halted/sp/stk_ovf/stk_unf.
//   slave  : sequencer side. It has the opposite directions.
interface pc_seq_unit_if #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 9,
  parameter int DEPTH = 4
);
  localparam int SP_W = $clog2(DEPTH + 1);

  logic                    en;
  logic [2:0]              op;
  logic                    take;
  logic signed [OFF_W-1:0] offset;
  logic [PC_W-1:0]         target;
  logic                    halt;
  logic                    resume;
  logic [PC_W-1:0]         pc;
  logic [PC_W-1:0]         npc;
  logic                    halted;
  logic [SP_W-1:0]         sp;
  logic                    stk_ovf;
  logic                    stk_unf;

  modport master (
    output en, op, take, offset, target, halt, resume,
    input  pc, npc, halted, sp, stk_ovf, stk_unf
  );

  modport slave (
    input  en, op, take, offset, target, halt, resume,
    output pc, npc, halted, sp, stk_ovf, stk_unf
  );
endinterface

// File: rtl/pc_seq_unit.sv
// Registered program-counter sequencer.
// It supports sequential advance, relative branches, absolute jumps, and
// call/return through a small LIFO return stack. It also supports stall
// (en=0) and halt/resume.
// Ports:
//   clk   - clock; all state updates on the rising edge
//   rst_n - synchronous active-low reset
//   bus   - pc_seq_unit_if.slave
//           inputs : en, op, take, offset, target, halt, resume
//           outputs: pc (registered), npc (combinational pc+1), halted,
//                    sp (valid stack entries), stk_ovf/stk_unf (sticky)
module pc_seq_unit #(
  parameter int              PC_W      = 10,
  parameter int              OFF_W     = 9,
  parameter int              DEPTH     = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_seq_unit_if.slave  bus
);
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_RUN, ST_HALT} state_t;
  typedef enum logic [2:0] {
    OP_NEXT = 3'b000,
    OP_BR   = 3'b001,
    OP_JMP  = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100
  } op_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            push;
  logic [PC_W-1:0] stk_q [DEPTH];
  logic [PC_W-1:0] npc;
  logic [PTR_W-1:0] push_idx;
  logic [PTR_W-1:0] pop_idx;
  logic [SP_W-1:0]  sp_m1;

  // Wrapping increment; the full-width add carries through every bit.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] base);
    return base + PC_W'(1);
  endfunction

  // The offset is sign-extended to PC_W before the add, so the sum wraps
  // modulo 2^PC_W in both directions.
  function automatic logic [PC_W-1:0] pc_add_rel(
    input logic [PC_W-1:0]         base,
    input logic signed [OFF_W-1:0] off
  );
    logic signed [PC_W-1:0] off_ext;
    off_ext = PC_W'(off);
    return base + off_ext;
  endfunction

  assign npc      = pc_inc(pc_q);
  assign sp_m1    = sp_q - SP_W'(1);
  assign push_idx = sp_q[PTR_W-1:0];
  assign pop_idx  = sp_m1[PTR_W-1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    case (state_q)
      ST_RUN: begin
        // halt outranks en and op; the op in that cycle is dropped.
        if (bus.halt) begin
          state_d = ST_HALT;
        end else if (bus.en) begin
          case (op_t'(bus.op))
            OP_BR:   pc_d = bus.take ? pc_add_rel(pc_q, bus.offset) : npc;
            OP_JMP:  pc_d = bus.target;
            OP_CALL: begin
              // The jump happens even when the stack is full.
              pc_d = bus.target;
              if (sp_q < SP_W'(DEPTH)) begin
                push = 1'b1;
                sp_d = sp_q + SP_W'(1);
              end else begin
                ovf_d = 1'b1;
              end
            end
            OP_RET: begin
              if (sp_q != '0) begin
                pc_d = stk_q[pop_idx];
                sp_d = sp_m1;
              end else begin
                pc_d  = npc;
                unf_d = 1'b1;
              end
            end
            default: pc_d = npc;
          endcase
        end
      end
      ST_HALT: begin
        if (bus.resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VEC;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage carries no reset. Only the push is suppressed while reset
  // is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && push) stk_q[push_idx] <= npc;
  end

  assign bus.pc      = pc_q;
  assign bus.npc     = npc;
  assign bus.halted  = (state_q == ST_HALT);
  assign bus.sp      = sp_q;
  assign bus.stk_ovf = ovf_q;
  assign bus.stk_unf = unf_q;
endmodule
